sync_mod_updown_counter: RTL and testbench

Fully synchronous, parametrised modulo-N up/down counter with enable, parallel load and cascade outputs. Generalises the team's 4-bit ripple up counter: one clock for all state bits, any width, programmable modulus, selectable direction. Used as the generic event/divider counter. Instances cascade through TC into the next stage's E.

---
 rtl/sync_mod_updown_counter_pkg.sv | 18 +
 rtl/sync_mod_updown_counter_next_state.sv | 59 +++++
 rtl/sync_mod_updown_counter.sv | 62 ++++++
 tb/tb_sync_mod_updown_counter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sync_mod_updown_counter_pkg.sv
// Shared counter definitions: direction encoding and load clamping.
// Meant to be reused by the timer/divider blocks built on this counter.
package sync_mod_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Widest counter the clamp helper supports; callers size the result down.
  localparam int CNT_MAX_W = 32;

  typedef logic [CNT_MAX_W-1:0] cnt_word_t;

  // Load values at or above the modulus saturate to the top count.
  function automatic cnt_word_t clamp_load(input cnt_word_t d, input cnt_word_t modulus);
    return (d < modulus) ? d : (modulus - cnt_word_t'(1));
  endfunction

endpackage

// File: rtl/sync_mod_updown_counter_next_state.sv
// Combinational next-count, wrap flag and terminal-count decode.
module sync_mod_updown_counter_next_state
  import sync_mod_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             i_clr,
  input  logic             i_e,
  input  logic             i_ld,
  input  logic             i_ud,
  input  logic [WIDTH-1:0] i_d,
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_q_nxt,
  output logic             o_wrap,
  output logic             o_tc
);

  // Top count; for MODULUS == 2**WIDTH this is all ones and wrap is natural overflow.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic             w_at_top;
  logic             w_at_bot;
  logic [WIDTH-1:0] w_ld_val;

  assign w_at_top = (i_q == MAX_Q);
  assign w_at_bot = (i_q == '0);
  assign w_ld_val = WIDTH'(clamp_load(CNT_MAX_W'(i_d), CNT_MAX_W'(MODULUS)));

  // Cascade output: asserted when the coming edge will wrap this stage.
  assign o_tc = i_e & ~i_ld & ~i_clr &
                (((i_ud == DIR_UP) & w_at_top) | ((i_ud == DIR_DOWN) & w_at_bot));

  // Next count: load beats count beats hold; clear is applied by the register.
  always_comb begin
    o_q_nxt = i_q;
    o_wrap  = 1'b0;
    if (i_ld) begin
      o_q_nxt = w_ld_val;
    end else if (i_e) begin
      if (i_ud == DIR_UP) begin
        if (w_at_top) begin
          o_q_nxt = '0;
          o_wrap  = 1'b1;
        end else begin
          o_q_nxt = i_q + WIDTH'(1);
        end
      end else begin
        if (w_at_bot) begin
          o_q_nxt = MAX_Q;
          o_wrap  = 1'b1;
        end else begin
          o_q_nxt = i_q - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sync_mod_updown_counter.sv
// Modulo-N up/down counter with enable, parallel load and cascade outputs.
// Holds only the count and overflow-pulse registers; decode lives in next_state.
module sync_mod_updown_counter
  import sync_mod_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_e,
  input  logic             i_ld,
  input  logic             i_ud,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_ovf
);

  // Reject moduli the counter cannot represent, and widths the clamp helper cannot hold.
  if (WIDTH < 1 || WIDTH > CNT_MAX_W - 2) begin : g_bad_width
    $error("sync_mod_updown_counter: WIDTH out of range");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_mod
    $error("sync_mod_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap;

  sync_mod_updown_counter_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_nxt (
    .i_clr  (i_clr),
    .i_e    (i_e),
    .i_ld   (i_ld),
    .i_ud   (i_ud),
    .i_d    (i_d),
    .i_q    (r_q),
    .o_q_nxt(w_q_nxt),
    .o_wrap (w_wrap),
    .o_tc   (o_tc)
  );

  // Count and one-cycle wrap pulse; clear overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_q   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ovf <= w_wrap;
    end
  end

  assign o_q   = r_q;
  assign o_ovf = r_ovf;

endmodule

// File: tb/tb_sync_mod_updown_counter.sv
// Bench: two cascaded modulo-10 stages plus a standalone 3-bit modulo-8 counter.
module tb_sync_mod_updown_counter;

  logic       clk = 1'b0;
  logic       clr, e, ld, ud;
  logic [3:0] d;
  logic       e2, ld2, ud2;
  logic [2:0] d2;

  logic [3:0] q0, q1;
  logic [2:0] q2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  typedef struct {
    int q0; int ovf0;
    int q1; int ovf1;
    int q2; int ovf2;
  } exp_t;

  exp_t sb[$];
  int   m_q0 = 0, m_q1 = 0, m_q2 = 0;
  int   n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  sync_mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_st0 (
    .i_clk(clk), .i_clr(clr), .i_e(e), .i_ld(ld), .i_ud(ud), .i_d(d),
    .o_q(q0), .o_tc(tc0), .o_ovf(ovf0)
  );

  sync_mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_st1 (
    .i_clk(clk), .i_clr(clr), .i_e(tc0), .i_ld(1'b0), .i_ud(ud), .i_d(4'd0),
    .o_q(q1), .o_tc(tc1), .o_ovf(ovf1)
  );

  sync_mod_updown_counter #(.WIDTH(3), .MODULUS(8)) u_m8 (
    .i_clk(clk), .i_clr(clr), .i_e(e2), .i_ld(ld2), .i_ud(ud2), .i_d(d2),
    .o_q(q2), .o_tc(tc2), .o_ovf(ovf2)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference: modular arithmetic on plain integers.
  function automatic int model_tc(input int q, input bit c, input bit l, input bit en,
                                  input bit up, input int mod);
    if (c || l || !en) return 0;
    return up ? int'(q == mod - 1) : int'(q == 0);
  endfunction

  function automatic void model_next(input int q, input bit c, input bit l, input bit en,
                                     input bit up, input int dv, input int mod,
                                     output int nq, output int novf);
    nq = q; novf = 0;
    if (c) nq = 0;
    else if (l) nq = (dv >= mod) ? mod - 1 : dv;
    else if (en) begin
      novf = up ? int'(q == mod - 1) : int'(q == 0);
      nq   = (q + (up ? 1 : mod - 1)) % mod;
    end
  endfunction

  // One clock: check TC before the edge, queue expected state, compare after the edge.
  task automatic step();
    int   t0, t1, t2;
    exp_t x;
    #1;
    t0 = model_tc(m_q0, clr, ld, e, ud, 10);
    t1 = model_tc(m_q1, clr, 1'b0, t0 != 0, ud, 10);
    t2 = model_tc(m_q2, clr, ld2, e2, ud2, 8);
    chk("tc0", int'(tc0), t0);
    chk("tc1", int'(tc1), t1);
    chk("tc2", int'(tc2), t2);
    model_next(m_q0, clr, ld, e, ud, int'(d), 10, x.q0, x.ovf0);
    model_next(m_q1, clr, 1'b0, t0 != 0, ud, 0, 10, x.q1, x.ovf1);
    model_next(m_q2, clr, ld2, e2, ud2, int'(d2), 8, x.q2, x.ovf2);
    m_q0 = x.q0; m_q1 = x.q1; m_q2 = x.q2;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q0", int'(q0), x.q0);   chk("ovf0", int'(ovf0), x.ovf0);
    chk("q1", int'(q1), x.q1);   chk("ovf1", int'(ovf1), x.ovf1);
    chk("q2", int'(q2), x.q2);   chk("ovf2", int'(ovf2), x.ovf2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b0; e = 1'b0; ld = 1'b0; ud = 1'b1; d = '0;
    e2 = 1'b0; ld2 = 1'b0; ud2 = 1'b1; d2 = '0;
    @(negedge clk);

    // Reset state
    e = 1'b1;
    do_reset();
    chk("rst_q0", int'(q0), 0);
    chk("rst_ovf0", int'(ovf0), 0);

    // Up count through one wrap: 12 edges from 0 ends at 2
    ud = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("up12_q0", int'(q0), 2);

    // Down count from 0: 12 edges ends at 8
    do_reset();
    ud = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("dn12_q0", int'(q0), 8);

    // Load wins over enable, then clamp
    ld = 1'b1; d = 4'd6; step();
    chk("ld6_q0", int'(q0), 6);
    d = 4'd13; step();
    chk("ld13_q0", int'(q0), 9);
    chk("ld13_ovf0", int'(ovf0), 0);

    // At Q=9 counting up, clear beats wrap and load
    ud = 1'b1; d = 4'd3; clr = 1'b1; step();
    clr = 1'b0; ld = 1'b0;
    chk("clrpri_q0", int'(q0), 0);
    chk("clrpri_ovf0", int'(ovf0), 0);

    // Cascade: 25 edges from reset gives {2,5}
    do_reset();
    e = 1'b1; ud = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("casc_q1", int'(q1), 2);
    chk("casc_q0", int'(q0), 5);

    // Modulo-8: enable toggles each cycle, direction flips when parked at 7
    e = 1'b0;
    do_reset();
    ud2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      e2 = i[0];
      if (e2 && m_q2 == 7) ud2 = ~ud2;
      step();
    end

    // Mixed random traffic on all inputs
    for (int i = 0; i < 300; i++) begin
      clr = ($urandom_range(31) == 0);
      ld  = ($urandom_range(7) == 0);
      e   = $urandom_range(3) != 0;
      ud  = $urandom_range(1) != 0;
      d   = 4'($urandom_range(15));
      ld2 = ($urandom_range(7) == 0);
      e2  = $urandom_range(1) != 0;
      ud2 = $urandom_range(1) != 0;
      d2  = 3'($urandom_range(7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
